alu_share_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 16-bit combinational ALU (AND/OR/ADD/SUB/SLT). Each requester issues one operation through a valid/ready handshake. The block picks a winner round-robin, registers its operands, drives the ALU for one cycle and captures the result. It then returns the result, tagged with the requester ID, through a valid/ready response channel.

---
 rtl/alu_share_arbiter.sv | 119 +++++++++++
 tb/tb_alu_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 16-bit ALU between two requesters.
// Optional rsp_zero result flag is enabled by defining ALU_SHARE_ARBITER_ZERO_FLAG_EN.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_SHARE_ARBITER_ZERO_FLAG_EN
  output logic             rsp_zero,
`endif
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last;
  logic             accept;
  logic             win_id;
  logic             lat_id;
  logic [2:0]       lat_op;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic             illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant is combinational in IDLE; rst_n gating keeps ready low while held in reset.
  always_comb begin
    accept     = 1'b0;
    win_id     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = (state == RESP);
    if ((state == IDLE) && rst_n && (req0_valid || req1_valid)) begin
      accept = 1'b1;
      win_id = (req0_valid && req1_valid) ? ~last : req1_valid;
    end
    req0_ready = accept && !win_id;
    req1_ready = accept && win_id;
  end

  assign illegal = (lat_op == 3'b011) || (lat_op == 3'b100) || (lat_op == 3'b101);

  // Operand latch on grant, result capture on the edge leaving EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      lat_id   <= 1'b0;
      lat_op   <= 3'b000;
      lat_a    <= '0;
      lat_b    <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        last   <= win_id;
        lat_id <= win_id;
        lat_op <= win_id ? req1_op : req0_op;
        lat_a  <= win_id ? req1_a  : req0_a;
        lat_b  <= win_id ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        rsp_id   <= lat_id;
        rsp_err  <= illegal;
        rsp_data <= illegal ? '0 : alu_s;
      end
    end
  end

`ifdef ALU_SHARE_ARBITER_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_zero <= 1'b0;
    else if (state == EXEC)  rsp_zero <= illegal || (alu_s == '0);
  end
`endif

  assign alu_x  = lat_a;
  assign alu_y  = lat_b;
  assign alu_op = lat_op;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model (also covers ALU_SHARE_ARBITER_ZERO_FLAG_EN).
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_x, alu_y, alu_s;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
`ifdef ALU_SHARE_ARBITER_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  alu_share_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_s(alu_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef ALU_SHARE_ARBITER_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU; illegal opcodes give a nonzero junk value the block must discard.
  always_comb begin
    case (alu_op)
      3'b000:  alu_s = alu_x & alu_y;
      3'b001:  alu_s = alu_x | alu_y;
      3'b010:  alu_s = alu_x + alu_y;
      3'b110:  alu_s = alu_x - alu_y;
      3'b111:  alu_s = ($signed(alu_x) < $signed(alu_y)) ? 16'd1 : 16'd0;
      default: alu_s = 16'hBEEF;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response of one operation: {err, data}.
  function automatic logic [16:0] spec_result(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  return {1'b0, a & b};
      3'b001:  return {1'b0, a | b};
      3'b010:  return {1'b0, a + b};
      3'b110:  return {1'b0, a - b};
      3'b111:  return {1'b0, (($signed(a) < $signed(b)) ? 16'd1 : 16'd0)};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  // Transaction-level model: block is busy from grant until the response is taken.
  bit          m_busy, m_rv, m_id, m_err, m_zero, m_last;
  int          m_cnt, m_g;
  logic [15:0] m_data, m_ax, m_ay;
  logic [2:0]  m_aop;
  bit          p_id;
  logic [16:0] p_res;

  int          grant_log[$];
  int          ri_log[$];
  logic [15:0] rd_log[$];
  int          re_log[$];
  bit          hold;
  bit          g0_act, g1_act;

  task automatic model_reset();
    m_busy = 0; m_rv = 0; m_id = 0; m_err = 0; m_zero = 0; m_last = 1;
    m_cnt = 0; m_g = -1; m_data = '0; m_ax = '0; m_ay = '0; m_aop = '0;
  endtask

  task automatic compare();
    int exp_g;
    exp_g = -1;
    if (rst_n && !m_busy) begin
      if (req0_valid && req1_valid) exp_g = m_last ? 0 : 1;
      else if (req0_valid)          exp_g = 0;
      else if (req1_valid)          exp_g = 1;
    end
    m_g = exp_g;
    chk("req0_ready", 16'(req0_ready), 16'(exp_g == 0));
    chk("req1_ready", 16'(req1_ready), 16'(exp_g == 1));
    chk("rsp_valid",  16'(rsp_valid),  16'(m_rv));
    chk("rsp_id",     16'(rsp_id),     16'(m_id));
    chk("rsp_data",   rsp_data,        m_data);
    chk("rsp_err",    16'(rsp_err),    16'(m_err));
    chk("alu_x",      alu_x,           m_ax);
    chk("alu_y",      alu_y,           m_ay);
    chk("alu_op",     16'(alu_op),     16'(m_aop));
`ifdef ALU_SHARE_ARBITER_ZERO_FLAG_EN
    chk("rsp_zero",   16'(rsp_zero),   16'(m_zero));
`endif
    g0_act = req0_ready;
    g1_act = req1_ready;
    if (req0_ready) grant_log.push_back(0);
    if (req1_ready) grant_log.push_back(1);
    if (rsp_valid && rsp_ready) begin
      ri_log.push_back(int'(rsp_id));
      rd_log.push_back(rsp_data);
      re_log.push_back(int'(rsp_err));
    end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (m_rv && rsp_ready) begin
      m_rv = 0; m_busy = 0;
    end else if (m_busy && m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_rv = 1; m_id = p_id; m_err = p_res[16]; m_data = p_res[15:0]; m_zero = (p_res[15:0] == 16'h0);
      end
    end
    if (m_g >= 0) begin
      m_busy = 1; m_cnt = 1; m_last = (m_g == 1); p_id = (m_g == 1);
      m_ax  = (m_g == 1) ? req1_a  : req0_a;
      m_ay  = (m_g == 1) ? req1_b  : req0_b;
      m_aop = (m_g == 1) ? req1_op : req0_op;
      p_res = spec_result(m_aop, m_ax, m_ay);
    end
  endtask

  // One clock: settle, compare, advance model, take the edge; granted requests drop unless held.
  task automatic tick();
    #1;
    compare();
    model_edge();
    @(posedge clk);
    #1;
    if (!hold && g0_act) req0_valid = 1'b0;
    if (!hold && g1_act) req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 3'b010; req1_op = 3'b010;
    req0_a = 16'h1; req0_b = 16'h1; req1_a = 16'h1; req1_b = 16'h1;
    rsp_ready = 1'b0; hold = 0;
    model_reset();
    tick();
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    grant_log.delete(); ri_log.delete(); rd_log.delete(); re_log.delete();
  endtask

  task automatic run_until_rsp(input int n, input string name);
    int k;
    k = 0;
    while (rd_log.size() < n && k < 60) begin
      tick();
      k++;
    end
    chk(name, 16'(rd_log.size()), 16'(n));
  endtask

  task automatic rand_op(output logic [2:0] op, output logic [15:0] a, output logic [15:0] b);
    op = 3'($urandom_range(7));
    a  = 16'($urandom);
    b  = ($urandom_range(3) == 0) ? a : 16'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Single ADD from requester 0.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 16'h0003; req0_b = 16'h0004;
    #1 chk("add_ready", 16'(req0_ready), 16'h1);
    tick();
    chk("add_n1_no_rsp", 16'(rsp_valid), 16'h0);
    tick();
    chk("add_n2_rsp_valid", 16'(rsp_valid), 16'h1);
    run_until_rsp(1, "add_timeout");
    if (rd_log.size() >= 1) begin
      chk("add_data", rd_log[0], 16'h0007);
      chk("add_id", 16'(ri_log[0]), 16'h0);
      chk("add_err", 16'(re_log[0]), 16'h0);
    end

    // Contention: both valid after reset, requester 0 first.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 16'h00F0; req0_b = 16'h0FF0;
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 16'h000F; req1_b = 16'h00F0;
    run_until_rsp(2, "cont_timeout");
    if (rd_log.size() >= 2) begin
      chk("cont_id0", 16'(ri_log[0]), 16'h0);
      chk("cont_data0", rd_log[0], 16'h00F0);
      chk("cont_id1", 16'(ri_log[1]), 16'h1);
      chk("cont_data1", rd_log[1], 16'h00FF);
    end

    // Fairness: both held valid for six grants.
    do_reset();
    rsp_ready = 1'b1; hold = 1;
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_valid = 1'b1; req1_op = 3'b110; req1_a = 16'h0009; req1_b = 16'h0002;
    for (int k = 0; k < 40 && grant_log.size() < 6; k++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0; hold = 0;
    chk("fair_count", 16'(grant_log.size()), 16'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("fair_order", 16'(grant_log[i]), 16'(i % 2));
    for (int k = 0; k < 4; k++) tick();

    // Backpressure on a SUB, requester 1 knocking during RESP.
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b110; req0_a = 16'h0010; req0_b = 16'h0001;
    for (int k = 0; k < 10 && !rsp_valid; k++) tick();
    chk("bp_reach_resp", 16'(rsp_valid), 16'h1);
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 16'h00FF; req1_b = 16'h0F0F;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_valid", 16'(rsp_valid), 16'h1);
      chk("bp_hold_data", rsp_data, 16'h000F);
      chk("bp_no_ready", 16'(req1_ready), 16'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_no_ready", 16'(req1_ready), 16'h0);
    tick();
    #1 chk("bp_idle_ready", 16'(req1_ready), 16'h1);
    run_until_rsp(2, "bp_timeout");
    if (rd_log.size() >= 2) chk("bp_second_data", rd_log[1], 16'h000F);

    // Illegal opcode from requester 1.
    do_reset();
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 16'h1234; req1_b = 16'h5678;
    run_until_rsp(1, "ill_timeout");
    if (rd_log.size() >= 1) begin
      chk("ill_id", 16'(ri_log[0]), 16'h1);
      chk("ill_data", rd_log[0], 16'h0000);
      chk("ill_err", 16'(re_log[0]), 16'h1);
    end

    // Reset while in EXEC.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 16'h1111; req0_b = 16'h2222;
    tick();
    chk("mid_alu_x_before", alu_x, 16'h1111);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_alu_x", alu_x, 16'h0000);
    chk("mid_alu_op", 16'(alu_op), 16'h0);
    chk("mid_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("mid_ready0", 16'(req0_ready), 16'h0);
    chk("mid_ready1", 16'(req1_ready), 16'h0);
    model_reset();
    tick();
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    rd_log.delete(); ri_log.delete(); re_log.delete();
    for (int k = 0; k < 3; k++) tick();
    chk("mid_no_stale", 16'(rd_log.size()), 16'h0);
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 16'h0F00; req1_b = 16'h00F0;
    run_until_rsp(1, "mid_timeout");
    if (rd_log.size() >= 1) begin
      chk("mid_after_data", rd_log[0], 16'h0FF0);
      chk("mid_after_id", 16'(ri_log[0]), 16'h1);
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!req0_valid && $urandom_range(2) == 0) begin
        req0_valid = 1'b1; rand_op(req0_op, req0_a, req0_b);
      end else if (req0_valid && $urandom_range(15) == 0) req0_valid = 1'b0;
      if (!req1_valid && $urandom_range(2) == 0) begin
        req1_valid = 1'b1; rand_op(req1_op, req1_a, req1_b);
      end else if (req1_valid && $urandom_range(15) == 0) req1_valid = 1'b0;
      rsp_ready = ($urandom_range(3) != 0);
      tick();
    end
    chk("rand_progress", 16'(rd_log.size() > 100), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
